// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty core and its instruction sequencer.
package bitty_pkg;

    // Opcode lives in instr[2:0]
    typedef enum logic [2:0] {
        OpInc = 3'd0,
        OpDec = 3'd1,
        OpNot = 3'd2,
        OpShr = 3'd3,
        OpShl = 3'd4,
        OpXor = 3'd5,
        OpAnd = 3'd6,
        OpClr = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSync = 2'd1,
        StRun  = 2'd2
    } seq_state_t;

    localparam int unsigned CORE_PERIOD = 4;

endpackage

// File: rtl/bitty_prog_mem.sv
// Program buffer: DEPTH x 16 register array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module bitty_prog_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bitty_sequencer.sv
// Feeds a loaded program to one bitty core, one instruction per core done pulse,
// and reports each result with its program index.
module bitty_sequencer
    import bitty_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = $clog2(DEPTH),
    parameter logic [15:0] IDLE_INSTR = 16'h0007,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    output logic          busy,
    output logic [15:0]   instr_out,
    input  logic          core_done,
    input  logic [15:0]   core_result,
    output logic          res_valid,
    output logic [15:0]   res_data,
    output logic [AW-1:0] res_idx,
    output logic          finished,
    output logic [15:0]   final_result,
    output logic          err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_t    state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   instr_q, instr_d;
    logic          res_valid_q, res_valid_d;
    logic [15:0]   res_data_q, res_data_d;
    logic [AW-1:0] res_idx_q, res_idx_d;
    logic          finished_q, finished_d;
    logic [15:0]   final_q, final_d;
    logic          err_q, err_d;

    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic [15:0]   mem_rdata;
    logic          last_instr;

    // Writes only land while idle and not colliding with a start request
    assign mem_we    = prog_we && (state_q == StIdle) && !start;
    // SYNC fetches entry 0; RUN prefetches the entry after the one in flight
    assign mem_raddr = (state_q == StRun) ? idx_q + AW'(1) : '0;

    bitty_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign last_instr = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        instr_d     = instr_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        finished_d  = 1'b0;
        final_d     = final_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                instr_d = IDLE_INSTR;
                timer_d = '0;
                if (start) begin
                    if (prog_len != '0) begin
                        state_d = StSync;
                        err_d   = 1'b0;
                        len_d   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
                    end else begin
                        finished_d = 1'b1;
                    end
                end
            end
            StSync, StRun: begin
                if (core_done) begin
                    timer_d = '0;
                    if (state_q == StSync) begin
                        instr_d = mem_rdata;
                        idx_d   = '0;
                        state_d = StRun;
                    end else begin
                        res_valid_d = 1'b1;
                        res_data_d  = core_result;
                        res_idx_d   = idx_q;
                        if (last_instr) begin
                            instr_d    = IDLE_INSTR;
                            final_d    = core_result;
                            finished_d = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            instr_d = mem_rdata;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    instr_d = IDLE_INSTR;
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                instr_d = IDLE_INSTR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            instr_q     <= IDLE_INSTR;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            finished_q  <= 1'b0;
            final_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            instr_q     <= instr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            finished_q  <= finished_d;
            final_q     <= final_d;
            err_q       <= err_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign instr_out    = instr_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_idx      = res_idx_q;
    assign finished     = finished_q;
    assign final_result = final_q;
    assign err          = err_q;

endmodule

// File: tb/tb_bitty_sequencer.sv
// Directed bench for bitty_sequencer with a behavioural 4-cycle bitty core model.
module tb_bitty_sequencer;

    logic        clk;
    logic        reset_n;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        busy;
    logic [15:0] instr_out;
    logic        core_done;
    logic [15:0] core_result;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  res_idx;
    logic        finished;
    logic [15:0] final_result;
    logic        err;

    int tests;
    int fails;

    bitty_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_len     (prog_len),
        .start        (start),
        .busy         (busy),
        .instr_out    (instr_out),
        .core_done    (core_done),
        .core_result  (core_result),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .finished     (finished),
        .final_result (final_result),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: updates its register every 4th edge and pulses done for one cycle
    logic [1:0]  ccnt;
    logic [15:0] creg;
    logic        craw;
    logic        done_en;

    function automatic logic [15:0] core_f(input logic [15:0] r, input logic [15:0] ins);
        case (ins[2:0])
            3'd0:    core_f = r + 16'd1;
            3'd2:    core_f = ~r;
            3'd4:    core_f = r << 1;
            3'd7:    core_f = 16'd0;
            default: core_f = r;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccnt <= 2'd0;
            creg <= 16'd0;
            craw <= 1'b0;
        end else begin
            ccnt <= ccnt + 2'd1;
            craw <= (ccnt == 2'd3);
            if (ccnt == 2'd3) creg <= core_f(creg, instr_out);
        end
    end

    assign core_done   = craw & done_en;
    assign core_result = creg;

    // Run capture (no checking here)
    logic [15:0] rd [16];
    logic [3:0]  ri [16];
    int          rn;
    bit          fin_seen;
    logic [15:0] fin_final;
    logic        fin_busy;
    logic        fin_rv;

    task automatic load(input logic [3:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_prog(input int max_c, input int inject, input int stop_res);
        rn = 0; fin_seen = 1'b0;
        for (int c = 0; c < max_c; c++) begin
            if (c == inject) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h0002;
            end
            @(posedge clk); #1;
            start = 1'b0; prog_we = 1'b0;
            if (res_valid) begin
                if (rn < 16) begin rd[rn] = res_data; ri[rn] = res_idx; end
                rn++;
            end
            if (finished) begin
                fin_seen = 1'b1; fin_final = final_result; fin_busy = busy; fin_rv = res_valid;
                break;
            end
            if (stop_res > 0 && rn == stop_res) break;
        end
    endtask

    task automatic test_reset();
        tests++; if (instr_out !== 16'h0007) begin fails++; $display("FAIL reset_instr got %h want 0007", instr_out); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        tests++; if (res_data !== 16'h0) begin fails++; $display("FAIL reset_res_data got %h want 0", res_data); end
        tests++; if (res_idx !== 4'h0) begin fails++; $display("FAIL reset_res_idx got %h want 0", res_idx); end
        tests++; if (finished !== 1'b0) begin fails++; $display("FAIL reset_finished got %b want 0", finished); end
        tests++; if (final_result !== 16'h0) begin fails++; $display("FAIL reset_final got %h want 0", final_result); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic check_scn1(input string tag);
        logic [15:0] exp_d [3];
        exp_d[0] = 16'd1; exp_d[1] = 16'd2; exp_d[2] = 16'd4;
        tests++; if (!fin_seen) begin fails++; $display("FAIL %s_finished got 0 want 1 (timeout)", tag); end
        tests++; if (rn !== 3) begin fails++; $display("FAIL %s_res_count got %0d want 3", tag, rn); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i < rn && (rd[i] !== exp_d[i] || ri[i] !== 4'(i))) begin
                fails++;
                $display("FAIL %s_res%0d got (%0d,%h) want (%0d,%h)", tag, i, ri[i], rd[i], i, exp_d[i]);
            end else if (i >= rn) begin
                fails++; $display("FAIL %s_res%0d got none want (%0d,%h)", tag, i, i, exp_d[i]);
            end
        end
        tests++; if (fin_final !== 16'd4) begin fails++; $display("FAIL %s_final got %h want 0004", tag, fin_final); end
        tests++; if (fin_busy !== 1'b0 || fin_rv !== 1'b1) begin
            fails++; $display("FAIL %s_fin_flags got busy=%b rv=%b want busy=0 rv=1", tag, fin_busy, fin_rv);
        end
        tests++; if (instr_out !== 16'h0007) begin fails++; $display("FAIL %s_idle_instr got %h want 0007", tag, instr_out); end
    endtask

    task automatic test_three_instr();
        load(4'd0, 16'h0000); load(4'd1, 16'h0000); load(4'd2, 16'h0004);
        prog_len = 5'd3;
        pulse_start();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL s1_busy got %b want 1", busy); end
        run_prog(40, -1, 0);
        check_scn1("s1");
    endtask

    task automatic test_single_not();
        load(4'd0, 16'h0002);
        prog_len = 5'd1;
        pulse_start();
        run_prog(40, -1, 0);
        tests++; if (!fin_seen || rn !== 1) begin fails++; $display("FAIL s2_run got fin=%b n=%0d want fin=1 n=1", fin_seen, rn); end
        tests++; if (rn >= 1 && (rd[0] !== 16'hFFFF || ri[0] !== 4'd0)) begin
            fails++; $display("FAIL s2_res got (%0d,%h) want (0,ffff)", ri[0], rd[0]);
        end
        tests++; if (fin_final !== 16'hFFFF) begin fails++; $display("FAIL s2_final got %h want ffff", fin_final); end
        @(posedge clk); #1;
        tests++; if (instr_out !== 16'h0007) begin fails++; $display("FAIL s2_idle_instr got %h want 0007", instr_out); end
    endtask

    task automatic test_timeout();
        done_en = 1'b0;
        prog_len = 5'd1;
        pulse_start();
        for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
        tests++; if (err !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL s3_pre_timeout got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        @(posedge clk); #1;
        tests++; if (err !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL s3_timeout got err=%b busy=%b want err=1 busy=0", err, busy);
        end
        tests++; if (instr_out !== 16'h0007 || finished !== 1'b0) begin
            fails++; $display("FAIL s3_after got instr=%h fin=%b want 0007 0", instr_out, finished);
        end
        done_en = 1'b1;
        @(posedge clk); #1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL s3_sticky got %b want 1", err); end
    endtask

    task automatic test_ignore_busy();
        load(4'd0, 16'h0000); load(4'd1, 16'h0000); load(4'd2, 16'h0004);
        prog_len = 5'd3;
        pulse_start();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL s4_err_clear got %b want 0", err); end
        run_prog(40, 6, 0);
        check_scn1("s4");
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL s4_err got %b want 0", err); end
    endtask

    task automatic test_zero_len();
        prog_len = 5'd0;
        pulse_start();
        tests++; if (finished !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL s5_pulse got fin=%b busy=%b rv=%b want 1 0 0", finished, busy, res_valid);
        end
        @(posedge clk); #1;
        tests++; if (finished !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0) begin
            fails++; $display("FAIL s5_after got fin=%b busy=%b rv=%b want 0 0 0", finished, busy, res_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        prog_len = 5'd3;
        pulse_start();
        run_prog(40, -1, 2);
        tests++; if (rn !== 2 || busy !== 1'b1) begin
            fails++; $display("FAIL s6_mid got n=%0d busy=%b want n=2 busy=1", rn, busy);
        end
        reset_n = 1'b0;
        #1;
        test_reset();
        #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        run_prog(40, -1, 0);
        check_scn1("s6");
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; done_en = 1'b1;
        #12;
        test_reset();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_three_instr();
        test_single_not();
        test_timeout();
        test_ignore_busy();
        test_zero_len();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
